cbd_eta2_stream: RTL and testbench

- Streaming centered-binomial sampler (eta = 2) for Kyber-768-90s.
- Sits between the PRF byte stream (AES-256-CTR keystream) and the NTT/polynomial buffer.
- Consumes 128 PRF bytes per polynomial over a valid/ready byte interface.
- Emits 256 coefficients, one per cycle, as canonical residues mod q plus an index, and flags polynomial completion.

---
 rtl/cbd_eta2_stream_if.sv | 27 ++
 rtl/cbd_eta2_stream.sv | 146 ++++++++++++++
 tb/tb_cbd_eta2_stream.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cbd_eta2_stream_if.sv
// Handshake bundle between the PRF byte source, the eta=2 CBD sampler and the
// polynomial sink: byte stream in, one mod-q coefficient per transfer out.
interface cbd_eta2_stream_if #(
    parameter int COEF_W = 12
);
    logic              start;
    logic [7:0]        in_byte;
    logic              in_valid;
    logic              in_ready;
    logic [COEF_W-1:0] coeff;
    logic signed [2:0] coeff_signed;
    logic [7:0]        coeff_idx;
    logic              coeff_valid;
    logic              coeff_ready;
    logic              busy;
    logic              done;

    modport slave (
        input  start, in_byte, in_valid, coeff_ready,
        output in_ready, coeff, coeff_signed, coeff_idx, coeff_valid, busy, done
    );

    modport master (
        output start, in_byte, in_valid, coeff_ready,
        input  in_ready, coeff, coeff_signed, coeff_idx, coeff_valid, busy, done
    );
endinterface

// File: rtl/cbd_eta2_stream.sv
// Streaming centered-binomial (eta=2) sampler: each PRF byte yields two
// coefficients in -2..2, emitted both signed and as canonical residues mod Q.
module cbd_eta2_stream #(
    parameter int N      = 256,
    parameter int Q      = 3329,
    parameter int COEF_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    cbd_eta2_stream_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EMIT_LO,
        EMIT_HI,
        DONE
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(N - 1);

    state_t            state;
    logic [3:0]        hi_nib_p0;
    logic [7:0]        idx;
    logic signed [2:0] coeff_s_p1;
    logic [COEF_W-1:0] coeff_p1;
    logic              vld_p1;
    logic              busy_q;
    logic              done_q;

    logic              last_hi;
    logic              accept;
    logic signed [2:0] lo_v;
    logic signed [2:0] hi_v;

    // a - c where a and c are the popcounts of the low and high bit pairs.
    function automatic logic signed [2:0] cbd_sample(input logic [3:0] nib);
        logic signed [2:0] a;
        logic signed [2:0] c;
        a = $signed({2'b00, nib[0]}) + $signed({2'b00, nib[1]});
        c = $signed({2'b00, nib[2]}) + $signed({2'b00, nib[3]});
        return a - c;
    endfunction

    function automatic logic [COEF_W-1:0] wrap_modq(input logic signed [2:0] v);
        logic signed [COEF_W:0] w;
        w = {{(COEF_W - 2){v[2]}}, v};
        if (v < 0) begin
            w = w + $signed((COEF_W + 1)'(Q));
        end
        return w[COEF_W-1:0];
    endfunction

    assign last_hi = (idx == LAST_IDX);
    assign lo_v    = cbd_sample(bus.in_byte[3:0]);
    assign hi_v    = cbd_sample(hi_nib_p0);

    // A byte may also be taken while the high coefficient leaves, so the
    // next low coefficient follows without a FETCH bubble.
    assign bus.in_ready = (state == FETCH) ||
                          ((state == EMIT_HI) && bus.coeff_ready && !last_hi);
    assign accept = bus.in_valid && bus.in_ready;

    assign bus.coeff        = coeff_p1;
    assign bus.coeff_signed = coeff_s_p1;
    assign bus.coeff_idx    = idx;
    assign bus.coeff_valid  = vld_p1;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            hi_nib_p0  <= '0;
            idx        <= '0;
            coeff_p1   <= '0;
            coeff_s_p1 <= '0;
            vld_p1     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= FETCH;
                        busy_q <= 1'b1;
                        idx    <= '0;
                    end
                end

                // p0 -> p1: byte captured, low coefficient registered at once
                FETCH: begin
                    if (accept) begin
                        hi_nib_p0  <= bus.in_byte[7:4];
                        coeff_s_p1 <= lo_v;
                        coeff_p1   <= wrap_modq(lo_v);
                        vld_p1     <= 1'b1;
                        state      <= EMIT_LO;
                    end
                end

                EMIT_LO: begin
                    if (bus.coeff_ready) begin
                        coeff_s_p1 <= hi_v;
                        coeff_p1   <= wrap_modq(hi_v);
                        idx        <= idx + 8'd1;
                        state      <= EMIT_HI;
                    end
                end

                EMIT_HI: begin
                    if (bus.coeff_ready) begin
                        if (last_hi) begin
                            vld_p1 <= 1'b0;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            idx <= idx + 8'd1;
                            if (accept) begin
                                hi_nib_p0  <= bus.in_byte[7:4];
                                coeff_s_p1 <= lo_v;
                                coeff_p1   <= wrap_modq(lo_v);
                                state      <= EMIT_LO;
                            end else begin
                                vld_p1 <= 1'b0;
                                state  <= FETCH;
                            end
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cbd_eta2_stream.sv
// Bench for cbd_eta2_stream: vector table, directed corner sequences and
// randomized backpressure against an arithmetic reference model.
module tb_cbd_eta2_stream;
    localparam int N      = 256;
    localparam int Q      = 3329;
    localparam int COEF_W = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cbd_eta2_stream_if #(.COEF_W(COEF_W)) bus ();

    cbd_eta2_stream #(.N(N), .Q(Q), .COEF_W(COEF_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        int coeff;
        int sval;
        int idx;
    } exp_t;

    typedef struct {
        logic [7:0] b;
        bit         new_poly;
        int         lo;
        int         lo_s;
        int         hi;
        int         hi_s;
    } vec_t;

    exp_t       exp_q[$];
    logic [7:0] src_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int first_xfer;
    int last_xfer;
    int bytes_taken;

    function automatic int model_v(input logic [7:0] b, input bit hi);
        int s;
        s = hi ? 4 : 0;
        return (int'(b[s]) + int'(b[s+1])) - (int'(b[s+2]) + int'(b[s+3]));
    endfunction

    task automatic push_model(input logic [7:0] b, input int k);
        int v;
        v = model_v(b, 1'b0);
        exp_q.push_back('{coeff: (v + Q) % Q, sval: v, idx: 2 * k});
        v = model_v(b, 1'b1);
        exp_q.push_back('{coeff: (v + Q) % Q, sval: v, idx: 2 * k + 1});
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic hard_reset();
        bus.start       = 1'b0;
        bus.in_valid    = 1'b0;
        bus.coeff_ready = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    // Drives src_q and consumes exp_q transfer by transfer.
    task automatic feed(input int vpct, input int rpct, input int start_at, input int budget);
        int   ptr;
        int   n;
        bit   full;
        bit   pv;
        bit   px;
        int   pc;
        int   ps;
        int   pi;
        exp_t e;
        ptr = 0; n = 0; pv = 1'b0; px = 1'b0; pc = 0; ps = 0; pi = 0;
        full = (src_q.size() == N / 2);
        first_xfer = -1;
        last_xfer  = -1;
        while (exp_q.size() > 0 && n < budget) begin
            bus.in_valid    = (ptr < src_q.size()) && (int'($urandom_range(0, 99)) < vpct);
            bus.in_byte     = (ptr < src_q.size()) ? src_q[ptr] : 8'($urandom);
            bus.coeff_ready = int'($urandom_range(0, 99)) < rpct;
            bus.start       = (start_at >= 0) && bus.coeff_valid &&
                              (int'(bus.coeff_idx) == start_at);
            #1;
            if (pv && !px) begin
                check("stall_valid", int'(bus.coeff_valid), 1);
                check("stall_coeff", int'(bus.coeff), pc);
                check("stall_signed", int'(bus.coeff_signed), ps);
                check("stall_idx", int'(bus.coeff_idx), pi);
            end
            check("early_done", int'(bus.done), 0);
            if (full && ptr == N / 2) check("extra_in_ready", int'(bus.in_ready), 0);
            px = bus.coeff_valid && bus.coeff_ready;
            if (px) begin
                e = exp_q.pop_front();
                check("coeff", int'(bus.coeff), e.coeff);
                check("coeff_signed", int'(bus.coeff_signed), e.sval);
                check("coeff_idx", int'(bus.coeff_idx), e.idx);
                if (first_xfer < 0) first_xfer = cyc;
                last_xfer = cyc;
            end
            pv = bus.coeff_valid;
            pc = int'(bus.coeff);
            ps = int'(bus.coeff_signed);
            pi = int'(bus.coeff_idx);
            if (bus.in_valid && bus.in_ready) ptr++;
            step();
            n++;
        end
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bytes_taken  = ptr;
        if (exp_q.size() > 0) begin
            check("timeout_pending_coeffs", exp_q.size(), 0);
            exp_q.delete();
        end
        src_q.delete();
    endtask

    task automatic make_random_poly();
        logic [7:0] b;
        for (int i = 0; i < N / 2; i++) begin
            b = 8'($urandom);
            src_q.push_back(b);
            push_model(b, i);
        end
    endtask

    task automatic end_checks(input string tag);
        check({tag, "_done"}, int'(bus.done), 1);
        check({tag, "_busy_low"}, int'(bus.busy), 0);
        check({tag, "_in_ready_low"}, int'(bus.in_ready), 0);
        check({tag, "_bytes"}, bytes_taken, N / 2);
        step();
        check({tag, "_done_clear"}, int'(bus.done), 0);
        check({tag, "_valid_low"}, int'(bus.coeff_valid), 0);
    endtask

    task automatic run_group();
        hard_reset();
        do_start();
        feed(100, 100, -1, 100);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[5];
        int   k;
        tbl[0] = '{b: 8'hEF, new_poly: 1'b1, lo: 0,    lo_s: 0,  hi: 3328, hi_s: -1};
        tbl[1] = '{b: 8'h33, new_poly: 1'b1, lo: 2,    lo_s: 2,  hi: 2,    hi_s: 2};
        tbl[2] = '{b: 8'hCC, new_poly: 1'b0, lo: 3327, lo_s: -2, hi: 3327, hi_s: -2};
        tbl[3] = '{b: 8'h00, new_poly: 1'b0, lo: 0,    lo_s: 0,  hi: 0,    hi_s: 0};
        tbl[4] = '{b: 8'h92, new_poly: 1'b0, lo: 1,    lo_s: 1,  hi: 0,    hi_s: 0};

        rst = 1'b1;
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_byte = 8'h00; bus.coeff_ready = 1'b0;
        #2 rst = 1'b0;
        step(); step(); step();
        check("rst_in_ready", int'(bus.in_ready), 0);
        check("rst_coeff_valid", int'(bus.coeff_valid), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_coeff", int'(bus.coeff), 0);
        check("rst_coeff_signed", int'(bus.coeff_signed), 0);
        check("rst_coeff_idx", int'(bus.coeff_idx), 0);
        rst = 1'b1;
        step();

        k = 0;
        for (int i = 0; i < 5; i++) begin
            if (tbl[i].new_poly && src_q.size() > 0) run_group();
            if (tbl[i].new_poly) k = 0;
            src_q.push_back(tbl[i].b);
            exp_q.push_back('{coeff: tbl[i].lo, sval: tbl[i].lo_s, idx: 2 * k});
            exp_q.push_back('{coeff: tbl[i].hi, sval: tbl[i].hi_s, idx: 2 * k + 1});
            k++;
        end
        run_group();

        // Full rate polynomial, then start on the done cycle and one after.
        hard_reset();
        check("idle_in_ready", int'(bus.in_ready), 0);
        do_start();
        check("start_busy", int'(bus.busy), 1);
        make_random_poly();
        feed(100, 100, -1, 400);
        check("full_rate_span", last_xfer - first_xfer, N - 1);
        check("full_done", int'(bus.done), 1);
        check("full_busy_low", int'(bus.busy), 0);
        check("full_in_ready_low", int'(bus.in_ready), 0);
        check("full_bytes", bytes_taken, N / 2);
        bus.start = 1'b1;
        step();
        check("start_on_done_ignored", int'(bus.busy), 0);
        check("after_done_in_ready", int'(bus.in_ready), 0);
        check("after_done_pulse_once", int'(bus.done), 0);
        step();
        bus.start = 1'b0;
        check("restart_busy", int'(bus.busy), 1);
        check("restart_in_ready", int'(bus.in_ready), 1);
        check("restart_idx", int'(bus.coeff_idx), 0);

        hard_reset();
        do_start();
        make_random_poly();
        feed(60, 50, -1, 3000);
        end_checks("bp50");

        hard_reset();
        do_start();
        make_random_poly();
        feed(90, 30, -1, 3000);
        end_checks("bp30");

        hard_reset();
        do_start();
        make_random_poly();
        feed(80, 50, 37, 3000);
        end_checks("start_busy37");

        // Reset in the middle of a polynomial.
        hard_reset();
        do_start();
        for (int i = 0; i < 10; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            src_q.push_back(b);
            push_model(b, i);
        end
        void'(exp_q.pop_back());
        feed(100, 100, -1, 200);
        check("pre_rst_valid", int'(bus.coeff_valid), 1);
        bus.coeff_ready = 1'b1;
        rst = 1'b0;
        #1;
        check("mid_rst_valid", int'(bus.coeff_valid), 0);
        check("mid_rst_busy", int'(bus.busy), 0);
        check("mid_rst_in_ready", int'(bus.in_ready), 0);
        check("mid_rst_idx", int'(bus.coeff_idx), 0);
        #1 rst = 1'b1;
        bus.coeff_ready = 1'b0;
        step();
        check("mid_rst_no_done", int'(bus.done), 0);
        do_start();
        for (int i = 0; i < 2; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            src_q.push_back(b);
            push_model(b, i);
        end
        feed(100, 100, -1, 50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
